// File: rtl/dram_bank_responder.sv
// Device-side model of one DRAM bank: ACT/RD/WR/PRE decode with a single open row,
// tRCD/tRP stalls, a fully pipelined CAS-latency read path and protocol-error flagging.
module dram_bank_responder #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int DATA_W = 32,
  parameter int T_RCD  = 2,
  parameter int T_CAS  = 3,
  parameter int T_RP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [DATA_W-1:0] wdata,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              row_open,
  output logic [ROW_W-1:0]  open_row,
  output logic              cmd_err
);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int DEPTH = 2 ** (ROW_W + COL_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_PRECHARGING
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               cmd_ready_reg, row_open_reg, cmd_err_reg, rdata_valid_reg;
  logic [ROW_W-1:0]   open_row_reg;
  logic [DATA_W-1:0]  rdata_reg;

  logic               accept;
  logic               ready_next, row_open_next, err_next;
  logic               rd_fire, wr_fire, act_fire;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  pipe_data [T_CAS];
  logic [T_CAS-1:0]   pipe_valid;
  logic [ROW_W+COL_W-1:0] mem_addr;

  assign accept   = cmd_valid & cmd_ready_reg;
  assign mem_addr = {open_row_reg, cmd_col};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; counters are loaded with T-1 so the stall lasts exactly T cycles
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && cmd == CMD_ACT) begin
          state_next = ST_ACTIVATING;
          cnt_next   = CNT_W'(T_RCD - 1);
        end
      end
      ST_ACTIVATING: begin
        if (cnt_reg == '0) state_next = ST_ACTIVE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      ST_ACTIVE: begin
        if (accept && cmd == CMD_PRE) begin
          state_next = ST_PRECHARGING;
          cnt_next   = CNT_W'(T_RP - 1);
        end
      end
      ST_PRECHARGING: begin
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    ready_next    = (state_next == ST_IDLE) || (state_next == ST_ACTIVE);
    row_open_next = (state_next == ST_ACTIVE);
    act_fire      = accept && (state_reg == ST_IDLE)   && (cmd == CMD_ACT);
    rd_fire       = accept && (state_reg == ST_ACTIVE) && (cmd == CMD_RD);
    wr_fire       = accept && (state_reg == ST_ACTIVE) && (cmd == CMD_WR);
    err_next      = 1'b0;
    if (accept) begin
      if (state_reg == ST_IDLE)
        err_next = (cmd == CMD_RD) || (cmd == CMD_WR);
      else if (state_reg == ST_ACTIVE)
        err_next = (cmd == CMD_ACT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_reg   <= 1'b1;
      row_open_reg    <= 1'b0;
      open_row_reg    <= '0;
      cmd_err_reg     <= 1'b0;
      pipe_valid      <= '0;
      rdata_valid_reg <= 1'b0;
      rdata_reg       <= '0;
    end else begin
      cmd_ready_reg <= ready_next;
      row_open_reg  <= row_open_next;
      cmd_err_reg   <= err_next;
      if (act_fire) open_row_reg <= cmd_row;
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < T_CAS; i++) pipe_valid[i] <= pipe_valid[i-1];
      rdata_valid_reg <= pipe_valid[T_CAS-1];
      if (pipe_valid[T_CAS-1]) rdata_reg <= pipe_data[T_CAS-1];
    end
  end

  // Array and read-data pipeline carry no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_fire) mem[mem_addr] <= wdata;
    if (rd_fire) pipe_data[0] <= mem[mem_addr];
    for (int i = 1; i < T_CAS; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign row_open    = row_open_reg;
  assign open_row    = open_row_reg;
  assign cmd_err     = cmd_err_reg;

endmodule
